// File: rtl/score_display_driver.sv
// Multi-digit 7-segment driver: binary value shown in decimal (serial double-dabble)
// or hex, with leading-zero blanking, overflow dashes and a blink mask.
//
// state  | meaning
// IDLE   | waiting for load; display holds last result
// SHIFT  | double-dabble conversion, one value bit per cycle
// UPDATE | copy converted/captured digits into the display registers
module score_display_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int BIN_WIDTH     = 14,
  parameter int BLANK_LEADING = 1,
  parameter int BLINK_DIV     = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blink_en,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    overflow
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int DW = $clog2(BLINK_DIV);
  localparam logic [63:0] DEC_MAX = 64'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t                  state, state_nxt;
  logic [BIN_WIDTH-1:0]    value_sr;
  logic [BW-1:0]           bcd, bcd_shift;
  logic [CW-1:0]           cnt;
  logic                    ovf_q;
  logic [7*NUM_DIGITS-1:0] disp, disp_nxt;
  logic [DW-1:0]           blink_cnt;
  logic                    blink_off;

  logic [BIN_WIDTH+BW-1:0] value_w;
  logic [BW-1:0]           hex_val;
  logic                    hex_ovf, dec_ovf, ovf_in;

  assign value_w = {{BW{1'b0}}, value};
  assign hex_val = value_w[BW-1:0];
  assign hex_ovf = |(value_w >> BW);
  assign dec_ovf = 64'(value) > DEC_MAX;
  assign ovf_in  = hex_mode ? hex_ovf : dec_ovf;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = (hex_mode || ovf_in) ? UPDATE : SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 on every nibble >= 5, then shift in the next value bit (MSB first).
  always_comb begin
    logic [BW-1:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    bcd_shift = {adj[BW-2:0], value_sr[BIN_WIDTH-1]};
  end

  always_comb begin
    logic lead;
    lead     = (BLANK_LEADING != 0);
    disp_nxt = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (ovf_q)
        disp_nxt[7*i +: 7] = 7'h3F;
      else if (lead && (bcd[4*i +: 4] == 4'h0) && (i != 0))
        disp_nxt[7*i +: 7] = 7'h7F;
      else begin
        disp_nxt[7*i +: 7] = seg7(bcd[4*i +: 4]);
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_sr <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_q    <= 1'b0;
      disp     <= '1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          ovf_q    <= ovf_in;
          value_sr <= value;
          cnt      <= CW'(BIN_WIDTH);
          if (hex_mode || ovf_in) begin
            bcd <= hex_val;
          end else begin
            bcd  <= '0;
            busy <= 1'b1;
          end
        end
        SHIFT: begin
          bcd      <= bcd_shift;
          value_sr <= {value_sr[BIN_WIDTH-2:0], 1'b0};
          cnt      <= cnt - CW'(1);
        end
        UPDATE: begin
          disp     <= disp_nxt;
          overflow <= ovf_q;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == DW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + DW'(1);
    end
  end

  // Blink mask sits after the display registers so blink_en acts immediately.
  assign hex_out = (blink_en && blink_off) ? '1 : disp;

endmodule

// File: tb/tb_score_display_driver.sv
// Scoreboard bench for score_display_driver: one blanking and one non-blanking instance
// share stimulus; expected digits come from an arithmetic decimal/hex model.
module tb_score_display_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        blink_en = 1'b0;
  logic [27:0] hex_out, hex_out_nb;
  logic        busy, overflow, busy_nb, overflow_nb;

  int checks = 0;
  int errors = 0;

  localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [27:0] disp;
    logic [27:0] disp_nb;
    logic        ovf;
    logic        busy1;
    int          lat;
  } exp_t;

  exp_t        sbq [$];
  logic [27:0] cur_disp = ALL_OFF;

  int m_cnt;
  bit m_off;

  score_display_driver #(.NUM_DIGITS(4), .BIN_WIDTH(14), .BLANK_LEADING(1), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
    .blink_en(blink_en), .hex_out(hex_out), .busy(busy), .overflow(overflow));

  score_display_driver #(.NUM_DIGITS(4), .BIN_WIDTH(14), .BLANK_LEADING(0), .BLINK_DIV(4)) dut_nb (
    .clk(clk), .reset(reset), .value(value), .load(load), .hex_mode(hex_mode),
    .blink_en(1'b0), .hex_out(hex_out_nb), .busy(busy_nb), .overflow(overflow_nb));

  always #5 clk = ~clk;

  // Reference blink phase: 4 cycles on, 4 cycles off, restarting at reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_off <= 1'b0;
    end else if (m_cnt == 3) begin
      m_cnt <= 0;
      m_off <= !m_off;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic [27:0] model_disp(input int unsigned v, input bit hexm, input bit blank,
                                             output bit ovf);
    int unsigned base, rem, msd;
    int unsigned digs [4];
    logic [27:0] d;
    base = hexm ? 16 : 10;
    ovf  = hexm ? ((v >> 16) != 0) : (v > 9999);
    rem  = v;
    msd  = 0;
    for (int i = 0; i < 4; i++) begin
      digs[i] = rem % base;
      rem     = rem / base;
      if (digs[i] != 0) msd = i;
    end
    for (int i = 0; i < 4; i++) begin
      if (ovf)                           d[7*i +: 7] = 7'h3F;
      else if (blank && i > 0 && i > msd) d[7*i +: 7] = 7'h7F;
      else                               d[7*i +: 7] = seg_tab[digs[i]];
    end
    return d;
  endfunction

  task automatic drive_load(input int unsigned v, input bit hexm);
    exp_t e;
    bit   o;
    @(negedge clk);
    value    = 14'(v);
    hex_mode = hexm;
    load     = 1'b1;
    e.disp    = model_disp(v, hexm, 1'b1, o);
    e.disp_nb = model_disp(v, hexm, 1'b0, o);
    e.ovf     = o;
    e.busy1   = !(hexm || o);
    e.lat     = (hexm || o) ? 1 : 15;
    sbq.push_back(e);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at the negedge just after the accepting edge.
  task automatic wait_result(input string name);
    exp_t        e;
    logic [27:0] prev;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e    = sbq.pop_front();
    prev = hex_out;
    checks++;
    if (busy !== e.busy1) begin
      errors++; $display("FAIL %s busy_start: got %b want %b", name, busy, e.busy1);
    end
    if (e.lat > 1) begin
      repeat (e.lat - 1) @(negedge clk);
      checks++;
      if (hex_out !== prev || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s hold: hex_out %h busy %b, want %h busy 1", name, hex_out, busy, prev);
      end
    end
    @(negedge clk);
    checks++;
    if (hex_out !== e.disp || overflow !== e.ovf || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: hex_out %h ovf %b busy %b, want %h ovf %b busy 0",
               name, hex_out, overflow, busy, e.disp, e.ovf);
    end
    checks++;
    if (hex_out_nb !== e.disp_nb) begin
      errors++; $display("FAIL %s noblank: got %h want %h", name, hex_out_nb, e.disp_nb);
    end
    cur_disp = e.disp;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (hex_out !== ALL_OFF || busy !== 1'b0 || overflow !== 1'b0 || hex_out_nb !== ALL_OFF) begin
      errors++;
      $display("FAIL reset: hex_out %h busy %b ovf %b, want %h 0 0", hex_out, busy, overflow, ALL_OFF);
    end
  endtask

  task automatic test_decimal();
    drive_load(1234, 1'b0); wait_result("dec_1234");
    drive_load(7, 1'b0);    wait_result("dec_7");
    drive_load(0, 1'b0);    wait_result("dec_0");
    drive_load(16383, 1'b0); wait_result("dec_16383_ovf");
    drive_load(9050, 1'b0); wait_result("dec_9050");
  endtask

  task automatic test_overflow();
    drive_load(10000, 1'b0); wait_result("ovf_10000");
    drive_load(9999, 1'b0);  wait_result("ovf_9999");
  endtask

  task automatic test_hex();
    drive_load(14'h1ABC, 1'b1); wait_result("hex_1abc");
    drive_load(14'h000F, 1'b1); wait_result("hex_000f");
    drive_load(14'h0D00, 1'b1); wait_result("hex_0d00");
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    bit          o;
    logic [27:0] hold;
    @(negedge clk);
    value = 14'd500; hex_mode = 1'b0; load = 1'b1;
    e.disp = model_disp(500, 1'b0, 1'b1, o);
    e.disp_nb = model_disp(500, 1'b0, 1'b0, o);
    e.ovf = o; e.busy1 = 1'b1; e.lat = 15;
    sbq.push_back(e);
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      load = 1'b0;
      if (j == 2 || j == 15) begin
        value = 14'd42; load = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (hex_out !== e.disp || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b result: hex_out %h busy %b ovf %b, want %h 0 0", hex_out, busy, overflow, e.disp);
    end
    cur_disp = e.disp;
    hold = hex_out;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hex_out !== hold) begin
      errors++;
      $display("FAIL b2b update_load: busy %b hex_out %h, want busy 0 hex_out %h", busy, hex_out, hold);
    end
  endtask

  task automatic test_blink();
    drive_load(1234, 1'b0); wait_result("blink_setup");
    @(negedge clk);
    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (hex_out !== (m_off ? ALL_OFF : cur_disp)) begin
        errors++;
        $display("FAIL blink[%0d]: got %h want %h", i, hex_out, m_off ? ALL_OFF : cur_disp);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 8 && !m_off; i++) @(negedge clk);
    blink_en = 1'b0;
    #1;
    checks++;
    if (hex_out !== cur_disp) begin
      errors++; $display("FAIL blink_off_release: got %h want %h", hex_out, cur_disp);
    end
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    value = 14'd4321; hex_mode = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (hex_out !== ALL_OFF || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: hex_out %h busy %b ovf %b, want %h 0 0", hex_out, busy, overflow, ALL_OFF);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_disp = ALL_OFF;
    repeat (20) @(negedge clk);
    checks++;
    if (hex_out !== ALL_OFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: hex_out %h busy %b, want %h 0", hex_out, busy, ALL_OFF);
    end
    drive_load(58, 1'b0); wait_result("after_reset_58");
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_overflow();
    test_hex();
    test_back_to_back();
    test_blink();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
